seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; power of two, 8..64.
REQ-002 SHALL have parameter STEP, default 8: maximum bits shifted per cycle; 1..WIDTH.
REQ-003 SHALL have i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have i_valid  in  1  request valid.
REQ-006 SHALL have o_ready  out  1  unit can accept a request.
REQ-007 SHALL have i_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 SHALL have i_rm  in  WIDTH  operand.
REQ-009 SHALL have i_amount  in  8  shift amount, unsigned.
REQ-010 SHALL have i_c  in  1  carry flag in.
REQ-011 SHALL have o_valid  out  1  result valid.
REQ-012 SHALL have i_ready  in  1  consumer accepts result.
REQ-013 SHALL have o_rd  out  WIDTH  result.
REQ-014 SHALL have o_c, o_z, o_n  out  1 each  carry, zero, negative flags.

Function
REQ-015 SHALL use states IDLE, SHIFT, DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-016 Request SHALL be accepted on an edge where i_valid && o_ready; i_op, i_rm, i_c and the effective amount E are captured then; inputs ignored at all other times.
REQ-017 E SHALL be: LSL/LSR min(i_amount, WIDTH+1); ASR min(i_amount, WIDTH); ROR i_amount mod WIDTH.
REQ-018 On accept, SHALL go to DONE if E==0, else SHIFT.
REQ-019 Each SHIFT cycle SHALL shift the working value by k=min(remaining, STEP) and decrement remaining by k; carry register = last bit shifted out (LSL: bit WIDTH-k pre-shift; LSR/ASR/ROR: bit k-1 pre-shift).
REQ-020 LSL/LSR SHALL fill with 0; ASR with operand MSB; ROR SHALL rotate bits shifted out into the opposite end.
REQ-021 SHIFT SHALL go to DONE on the cycle remaining reaches 0; o_valid first high N+1 edges after the accept edge, N=ceil(E/STEP).
REQ-022 i_amount==0 (any op): o_rd=i_rm, o_c=i_c.
REQ-023 ROR with i_amount!=0 and E==0: o_rd=i_rm, o_c=i_rm[WIDTH-1].
REQ-024 Saturation SHALL give: LSL/LSR amount==WIDTH -> o_rd 0, o_c = i_rm[0] (LSL) / i_rm[WIDTH-1] (LSR); amount>WIDTH -> o_rd 0, o_c 0; ASR amount>=WIDTH -> o_rd and o_c all sign bit.
REQ-025 o_z = (o_rd==0); o_n = o_rd[WIDTH-1]; SHALL be valid whenever o_valid.
REQ-026 In DONE, o_rd and flags SHALL hold stable until i_ready; DONE && i_ready -> IDLE next edge; no accept in the same cycle (o_ready low in DONE).
REQ-027 i_valid SHALL be ignored outside IDLE; no request queuing.

Reset
REQ-028 i_rst high at an edge SHALL force IDLE, o_valid 0, o_rd 0, o_c/o_z/o_n 0, remaining 0, regardless of state; o_ready 1 from the first edge after reset.
REQ-029 Reset in SHIFT or DONE SHALL discard the operation; no result is produced.
REQ-030 i_rst SHALL take priority over i_valid and i_ready on the same edge.

Verification (WIDTH=32, STEP=8)
REQ-031 LSR, rm=0x80000001, amount 1 -> o_rd 0x40000000, C1 Z0 N0, o_valid 2 edges after accept.
REQ-032 LSR, rm=0x80000000, amount 32 -> o_rd 0, C1 Z1 N0, o_valid 5 edges after accept; same with amount 200 -> C0.
REQ-033 ASR, rm=0x80000000, amount 40 -> o_rd 0xFFFFFFFF, C1 N1; LSL, rm=0x1, amount 31 -> 0x80000000, C0 N1.
REQ-034 ROR, rm=0x0000000F, amount 4 -> 0xF0000000, C1 N1; amount 32, rm=0x1 -> o_rd 0x1, C0, o_valid 1 edge after accept.
REQ-035 LSL amount 0, rm=0x12345678, i_c=1 -> o_rd 0x12345678, C1; hold i_ready low 5 cycles -> outputs stable, o_ready low, new i_valid ignored.
REQ-036 Assert i_rst during SHIFT of LSR by 24 -> IDLE, o_valid never high, all outputs 0; following request completes correctly.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-less shifter (LSL/LSR/ASR/ROR) with
// ARM-style carry-out and saturation. It moves at most STEP bits per cycle,
// so the latency depends on the effective amount. The request side uses a
// valid/ready handshake, and the result is held in DONE until the consumer
// accepts it.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rm,
  input  logic [7:0]       i_amount,
  input  logic             i_c,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_c,
  output logic             o_z,
  output logic             o_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Amounts never exceed WIDTH+1 (at most 65), so 8 bits covers every count.
  localparam logic [7:0] WIDTH_L = 8'(WIDTH);
  localparam logic [7:0] STEP_L  = 8'(STEP);

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] val_reg, val_next;
  logic             c_reg, c_next;
  logic [7:0]       rem_reg, rem_next;

  logic [7:0]       amt_eff;
  logic [7:0]       k;
  logic [WIDTH-1:0] lsl_val, lsr_val, asr_val, ror_val;
  logic [WIDTH-1:0] lsl_out_bits, right_out_bits;
  logic             carry_lsl, carry_right;

  // Effective amount. LSL/LSR saturate at WIDTH+1, which is enough to
  // produce the "everything shifted out, carry 0" case. ASR saturates at
  // WIDTH, where the result is all sign bits. ROR wraps modulo WIDTH.
  always_comb begin
    amt_eff = i_amount;
    case (i_op)
      OP_LSL, OP_LSR: begin
        if (i_amount > WIDTH_L + 8'd1) amt_eff = WIDTH_L + 8'd1;
      end
      OP_ASR: begin
        if (i_amount > WIDTH_L) amt_eff = WIDTH_L;
      end
      default: begin
        amt_eff = i_amount & (WIDTH_L - 8'd1);
      end
    endcase
  end

  // Per-cycle datapath: shift by k = min(remaining, STEP) and extract the
  // last bit that leaves the word. The carry bit is taken with a shift
  // instead of a variable index, so no out-of-range select can occur while
  // k is 0 outside SHIFT.
  always_comb begin
    k              = (rem_reg < STEP_L) ? rem_reg : STEP_L;
    lsl_val        = val_reg << k;
    lsr_val        = val_reg >> k;
    asr_val        = $signed(val_reg) >>> k;
    ror_val        = (val_reg >> k) | (val_reg << (WIDTH_L - k));
    lsl_out_bits   = val_reg >> (WIDTH_L - k);
    right_out_bits = val_reg >> (k - 8'd1);
    carry_lsl      = lsl_out_bits[0];
    carry_right    = right_out_bits[0];
  end

  // Next-state and working-register update.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    val_next   = val_reg;
    c_next     = c_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          op_next  = i_op;
          val_next = i_rm;
          rem_next = amt_eff;
          // A non-zero ROR that wraps to 0 still reports the MSB as carry.
          // Any other zero amount passes the incoming carry through.
          if (i_op == OP_ROR && i_amount != 8'd0) c_next = i_rm[WIDTH-1];
          else                                   c_next = i_c;
          state_next = (amt_eff == 8'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        case (op_reg)
          OP_LSL: begin
            val_next = lsl_val;
            c_next   = carry_lsl;
          end
          OP_LSR: begin
            val_next = lsr_val;
            c_next   = carry_right;
          end
          OP_ASR: begin
            val_next = asr_val;
            c_next   = carry_right;
          end
          default: begin
            val_next = ror_val;
            c_next   = carry_right;
          end
        endcase
        rem_next = rem_reg - k;
        if (rem_reg == k) state_next = DONE;
      end
      DONE: begin
        if (i_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset clears everything and overrides any handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      op_reg    <= OP_LSL;
      val_reg   <= '0;
      c_reg     <= 1'b0;
      rem_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      val_reg   <= val_next;
      c_reg     <= c_next;
      rem_reg   <= rem_next;
    end
  end

  // Outputs. o_z is qualified by DONE so that it reads 0 after reset, even
  // though the working value is 0 then.
  always_comb begin
    o_ready = (state_reg == IDLE);
    o_valid = (state_reg == DONE);
    o_rd    = val_reg;
    o_c     = c_reg;
    o_n     = val_reg[WIDTH-1];
    o_z     = (state_reg == DONE) && (val_reg == '0);
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed, table-driven bench for seq_shifter (WIDTH=32,
// STEP=8). It also runs hand-written sequences for result hold/backpressure
// and for reset in the SHIFT and DONE states.
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 8;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic             i_clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_rm;
  logic [7:0]       i_amount;
  logic             i_c;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_rd;
  logic             o_c;
  logic             o_z;
  logic             o_n;

  int n_cmp = 0;
  int n_bad = 0;

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_rm    (i_rm),
    .i_amount(i_amount),
    .i_c     (i_c),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_rd    (o_rd),
    .o_c     (o_c),
    .o_z     (o_z),
    .o_n     (o_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rm;
    logic [7:0]  amt;
    logic        c;
    logic [31:0] rd;
    logic        ec;
    logic        ez;
    logic        en;
    int          lat;   // edges from accept (counted as 1) to first o_valid
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for o_valid. On return, lat holds the
  // edge count with the accept edge counted as 1.
  task automatic run_req(input logic [1:0] op, input logic [31:0] rm,
                         input logic [7:0] amt, input logic c, output int lat);
    int w;
    w = 0;
    while (!o_ready && w < 50) begin
      tick();
      w++;
    end
    i_op     = op;
    i_rm     = rm;
    i_amount = amt;
    i_c      = c;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    // Scramble the inputs so that any use of uncaptured data shows up.
    i_rm     = ~rm;
    i_amount = 8'hAA;
    i_c      = ~c;
    lat = 1;
    while (!o_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_req();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{LSR, 32'h80000001, 8'd1,   1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 2};
    vecs[1]  = '{LSR, 32'h80000000, 8'd32,  1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 5};
    vecs[2]  = '{LSR, 32'h80000000, 8'd200, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 6};
    vecs[3]  = '{ASR, 32'h80000000, 8'd40,  1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 5};
    vecs[4]  = '{LSL, 32'h00000001, 8'd31,  1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 5};
    vecs[5]  = '{ROR, 32'h0000000F, 8'd4,   1'b0, 32'hF0000000, 1'b1, 1'b0, 1'b1, 2};
    vecs[6]  = '{ROR, 32'h00000001, 8'd32,  1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{LSL, 32'h12345678, 8'd0,   1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{LSL, 32'h80000001, 8'd32,  1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 5};
    vecs[9]  = '{LSL, 32'hFFFFFFFF, 8'd33,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 6};
    vecs[10] = '{ASR, 32'h7FFFFFFF, 8'd32,  1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 5};
    vecs[11] = '{ROR, 32'h80000001, 8'd33,  1'b0, 32'hC0000000, 1'b1, 1'b0, 1'b1, 2};
    vecs[12] = '{LSR, 32'h12345678, 8'd12,  1'b1, 32'h00012345, 1'b0, 1'b0, 1'b0, 3};
    vecs[13] = '{ASR, 32'h87654321, 8'd4,   1'b1, 32'hF8765432, 1'b0, 1'b0, 1'b1, 2};
    vecs[14] = '{LSL, 32'h87654321, 8'd8,   1'b0, 32'h65432100, 1'b1, 1'b0, 1'b0, 2};
    vecs[15] = '{ROR, 32'h12345678, 8'd20,  1'b1, 32'h45678123, 1'b0, 1'b0, 1'b0, 4};
    vecs[16] = '{ASR, 32'h80000000, 8'd0,   1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    vecs[17] = '{LSR, 32'h00000001, 8'd1,   1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 2};
    vecs[18] = '{ROR, 32'h00000001, 8'd255, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 5};

    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_op     = LSL;
    i_rm     = '0;
    i_amount = 8'd0;
    i_c      = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst o_ready", o_ready, 1'b1);
    check("rst o_valid", o_valid, 1'b0);
    check("rst o_rd",    o_rd,    32'h0);
    check("rst o_c",     o_c,     1'b0);
    check("rst o_z",     o_z,     1'b0);
    check("rst o_n",     o_n,     1'b0);
    i_rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      run_req(vecs[i].op, vecs[i].rm, vecs[i].amt, vecs[i].c, lat);
      $display("vec %0d: op=%0d rm=%h amt=%0d c=%0b -> rd=%h c=%0b z=%0b n=%0b lat=%0d",
               i, vecs[i].op, vecs[i].rm, vecs[i].amt, vecs[i].c, o_rd, o_c, o_z, o_n, lat);
      check($sformatf("v%0d o_rd", i),    o_rd, vecs[i].rd);
      check($sformatf("v%0d o_c", i),     o_c,  vecs[i].ec);
      check($sformatf("v%0d o_z", i),     o_z,  vecs[i].ez);
      check($sformatf("v%0d o_n", i),     o_n,  vecs[i].en);
      check($sformatf("v%0d latency", i), lat,  vecs[i].lat);
      finish_req();
      check($sformatf("v%0d o_valid drop", i), o_valid, 1'b0);
      check($sformatf("v%0d o_ready back", i), o_ready, 1'b1);
    end

    // Hold in DONE under backpressure while new requests are ignored
    run_req(LSL, 32'h12345678, 8'd0, 1'b1, lat);
    $display("hold: rd=%h c=%0b lat=%0d", o_rd, o_c, lat);
    check("hold latency", lat, 1);
    i_valid  = 1'b1;
    i_op     = ROR;
    i_rm     = 32'hDEADBEEF;
    i_amount = 8'd5;
    i_c      = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("hold%0d o_valid", j), o_valid, 1'b1);
      check($sformatf("hold%0d o_ready", j), o_ready, 1'b0);
      check($sformatf("hold%0d o_rd", j),    o_rd,    32'h12345678);
      check($sformatf("hold%0d o_c", j),     o_c,     1'b1);
    end
    i_valid = 1'b0;
    finish_req();
    check("hold release o_valid", o_valid, 1'b0);
    check("hold release o_ready", o_ready, 1'b1);
    tick();
    check("hold no queued req", o_valid, 1'b0);

    // Reset during SHIFT discards the operation
    i_op     = LSR;
    i_rm     = 32'hFFFFFFFF;
    i_amount = 8'd24;
    i_c      = 1'b1;
    i_valid  = 1'b1;
    tick();
    i_valid = 1'b0;
    check("shift o_ready low", o_ready, 1'b0);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    $display("rst-in-shift: rd=%h c=%0b z=%0b n=%0b valid=%0b", o_rd, o_c, o_z, o_n, o_valid);
    check("rst-shift o_valid", o_valid, 1'b0);
    check("rst-shift o_ready", o_ready, 1'b1);
    check("rst-shift o_rd",    o_rd,    32'h0);
    check("rst-shift o_c",     o_c,     1'b0);
    check("rst-shift o_z",     o_z,     1'b0);
    check("rst-shift o_n",     o_n,     1'b0);
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (o_valid) seen++;
    end
    check("rst-shift no result", seen, 0);
    run_req(LSR, 32'h80000001, 8'd1, 1'b0, lat);
    $display("after rst: rd=%h c=%0b lat=%0d", o_rd, o_c, lat);
    check("post-rst o_rd",    o_rd, 32'h40000000);
    check("post-rst o_c",     o_c,  1'b1);
    check("post-rst latency", lat,  2);
    finish_req();

    // Reset during DONE, together with i_ready, wins and clears the result
    run_req(ASR, 32'h80000000, 8'd3, 1'b0, lat);
    check("done-rst pre o_rd", o_rd, 32'hF0000000);
    i_rst   = 1'b1;
    i_ready = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_ready = 1'b0;
    $display("rst-in-done: rd=%h c=%0b valid=%0b", o_rd, o_c, o_valid);
    check("rst-done o_valid", o_valid, 1'b0);
    check("rst-done o_rd",    o_rd,    32'h0);
    check("rst-done o_c",     o_c,     1'b0);
    check("rst-done o_n",     o_n,     1'b0);

    // Reset takes priority over i_valid in IDLE: no request is accepted
    i_op     = LSL;
    i_rm     = 32'hA5A5A5A5;
    i_amount = 8'd0;
    i_c      = 1'b1;
    i_valid  = 1'b1;
    i_rst    = 1'b1;
    tick();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    $display("rst+valid: valid=%0b ready=%0b rd=%h", o_valid, o_ready, o_rd);
    check("rst-prio o_valid", o_valid, 1'b0);
    check("rst-prio o_ready", o_ready, 1'b1);
    check("rst-prio o_rd",    o_rd,    32'h0);
    tick();
    check("rst-prio still idle", o_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
